pipelined_adder_nb: RTL
=======================

Name: pipelined_adder_nb

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple full adder.
- Splits a WIDTH-bit add or subtract into SLICE-bit ripple slices, one slice per pipeline stage.
- Accepts one operand pair per clock, with valid tagging and a global stall.
- Feeds the MAC/accumulator datapath of the digit-detection network, where wide single-cycle carries limit Fmax.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of SLICE (elaboration error otherwise)
SLICE, 4, bits resolved per pipeline stage; STAGES = WIDTH/SLICE (must be >= 1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high
in_valid  input  1  operands on a, b, c_in, sub are valid this cycle
stall  input  1  1 = freeze entire pipeline (all registers hold)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry in to slice 0
sub  input  1  0 = a + b + c_in; 1 = a + ~b + c_in (c_in=1 gives a-b)
out_valid  output  1  s/c_out hold a valid result
s  output  WIDTH  sum
c_out  output  1  carry out of MSB slice

Behaviour:
- Reset (async assert, any cycle): clear all pipeline registers, valid bits, s, c_out, out_valid to 0. Discard in-flight data; no partial result emerges after release.
- Operand capture: on a rising edge with stall=0, form b' = sub ? ~b : b.
- Stage 0 computes slice 0: {carry, sum[SLICE-1:0]} = a[SLICE-1:0] + b'[SLICE-1:0] + c_in.
- Stage 0 registers that slice sum, its carry, the valid bit, and the unconsumed upper slices of a and b' (skew registers).
- Stage i (1..STAGES-1) adds slice i of the delayed operands plus the registered carry from stage i-1.
- Stage i passes already-computed lower sum slices forward (deskew) and remaining upper operand slices.
- Stage STAGES-1 registers are the outputs: s = all slices concatenated, c_out = last slice carry, out_valid = propagated valid.
- Latency: operands captured at edge k (in_valid=1, stall=0) appear on s/c_out/out_valid after edge k+STAGES-1, i.e. STAGES register stages. With WIDTH=16, SLICE=4: result visible in the cycle after the 4th edge counting the capture edge.
- Throughput: 1 result/clock when stall=0.
- Bubbles: in_valid=0 propagates out_valid=0. Data registers may load don't-care, but are gated to keep their previous value (required for power/visibility).
- Stall: when stall=1, every register holds, including outputs. in_valid is ignored that cycle; the operand is not captured and upstream must re-present it. On deassert, the pipeline resumes with no loss or duplication.
- Simultaneous stall=1 and rst=1: reset wins.
- Wrap-around: sum modulo 2^WIDTH; the carry lives only in c_out.
- STAGES=1 (SLICE=WIDTH): degenerates to a registered single-cycle adder, latency 1.
- Output s and c_out are held stable while out_valid=0; they are only updated by a valid result.

Optional Feature:
- Macro ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit) = signed overflow = carry into MSB XOR carry out of MSB, computed in the last stage.
  - ovf is aligned with s/c_out, reset to 0, and held under stall/bubble like s.
- Undefined: port ovf does not exist; no overflow logic is synthesised.

Test Plan:
1. WIDTH=16, SLICE=4; a=0xFFFF, b=0x0000, c_in=1, sub=0 -> after 4 stages s=0x0000, c_out=1, out_valid=1 for one cycle.
2. Back-to-back stream on 4 consecutive cycles: (0xFFFF+0x0000+0), (0x0000+0xFFFF+0), (0xAAAA+0x5555+1), (0xFFFF+0xFFFF+1) -> s=0xFFFF/c0, 0xFFFF/c0, 0x0000/c1, 0xFFFF/c1 on 4 consecutive output cycles.
3. Subtract: a=0x0005, b=0x0007, c_in=1, sub=1 -> s=0xFFFE, c_out=0; then a=0x0007, b=0x0005 -> s=0x0002, c_out=1.
4. Stall: stream 3 ops, assert stall for 3 cycles mid-flight -> outputs frozen during stall; all 3 results appear in order after release, no duplicates or drops.
5. Reset mid-operation: 2 ops in flight, pulse rst asynchronously between edges -> s=0, c_out=0, out_valid=0 immediately; no stale result emerges on later cycles.
6. With ADDER_OVF_EN: 0x7FFF+0x0001 -> s=0x8000, ovf=1; 0x8000-0x0001 (sub=1, c_in=1) -> s=0x7FFF, ovf=1; 0x0001+0x0001 -> ovf=0.

Source files
------------

// File: rtl/pipelined_adder_nb.sv
// Pipelined WIDTH-bit adder/subtractor resolving SLICE bits per stage, with valid tagging and global stall.
// Define ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder_nb #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / SLICE;

  if ((SLICE < 1) || (WIDTH % SLICE != 0) || (STAGES < 1)) begin : g_bad_params
    $error("pipelined_adder_nb: WIDTH must be a positive multiple of SLICE");
  end

  // Stage g consumes the low slice of its incoming operands, forwards the rest
  // (skew), and appends its sum slice above the lower slices already resolved (deskew).
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    localparam int WIN  = WIDTH - g * SLICE;
    localparam int WSUM = (g + 1) * SLICE;

    logic [WIN-1:0]  op_a;
    logic [WIN-1:0]  op_b;
    logic            cin;
    logic            vin;
    logic [SLICE:0]  res;
    logic [WSUM-1:0] sum_new;

    logic            valid_q, valid_d;
    logic            carry_q, carry_d;
    logic [WSUM-1:0] sum_q, sum_d;

    if (g == 0) begin : g_head
      assign op_a    = a;
      assign op_b    = sub ? ~b : b;
      assign cin     = c_in;
      assign vin     = in_valid;
      assign sum_new = res[SLICE-1:0];
    end else begin : g_body
      assign op_a    = g_stage[g-1].g_skew.a_q;
      assign op_b    = g_stage[g-1].g_skew.b_q;
      assign cin     = g_stage[g-1].carry_q;
      assign vin     = g_stage[g-1].valid_q;
      assign sum_new = {res[SLICE-1:0], g_stage[g-1].sum_q};
    end

    always_comb begin
      res = {1'b0, op_a[SLICE-1:0]} + {1'b0, op_b[SLICE-1:0]} + {{SLICE{1'b0}}, cin};
      valid_d = vin;
      carry_d = carry_q;
      sum_d   = sum_q;
      // Data registers load only on a valid token so bubbles leave them untouched.
      if (vin) begin
        carry_d = res[SLICE];
        sum_d   = sum_new;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (!stall) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (WIN > SLICE) begin : g_skew
      logic [WIN-SLICE-1:0] a_q, a_d;
      logic [WIN-SLICE-1:0] b_q, b_d;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (vin) begin
          a_d = op_a[WIN-1:SLICE];
          b_d = op_b[WIN-1:SLICE];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign s         = g_stage[STAGES-1].sum_q;
  assign c_out     = g_stage[STAGES-1].carry_q;

`ifdef ADDER_OVF_EN
  logic ovf_q, ovf_d;
  logic msb_cin;

  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  always_comb begin
    msb_cin = g_stage[STAGES-1].op_a[SLICE-1] ^ g_stage[STAGES-1].op_b[SLICE-1]
            ^ g_stage[STAGES-1].res[SLICE-1];
    ovf_d   = ovf_q;
    if (g_stage[STAGES-1].vin) begin
      ovf_d = msb_cin ^ g_stage[STAGES-1].res[SLICE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
